baud_tick_gen: RTL
==================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter DIV_W, default 16, width of divisor and prescale counter.
REQ-002 Parameter OSR, default 16, oversample ticks per bit; even, >= 4.
REQ-003 Parameter DEF_DIV, default 16'd27, divisor in effect after reset; 1 <= DEF_DIV < 2**DIV_W.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 CE  input  1  count enable; low freezes prescale and oversample counters.
REQ-007 LOAD  input  1  one-cycle strobe, capture D as new divisor and restart phase.
REQ-008 D  input  DIV_W  divisor value sampled on LOAD.
REQ-009 RESTART  input  1  one-cycle strobe, realign phase (RX start-bit detect), divisor unchanged.
REQ-010 OS_TICK  output  1  oversample tick, one-cycle pulse.
REQ-011 MID_TICK  output  1  mid-bit sample tick, one-cycle pulse.
REQ-012 BIT_TICK  output  1  bit-boundary tick, one-cycle pulse.
REQ-013 DIV  output  DIV_W  divisor currently in effect.

Function
REQ-014 Divisor register div_r holds the active divisor; LOAD with D=0 SHALL store 1 (divide-by-1).
REQ-015 Prescale counter pc SHALL count down from div_r-1 to 0 while CE=1, reloading div_r-1 in the cycle after reaching 0.
REQ-016 OS_TICK SHALL be a registered pulse, high for exactly one cycle following each cycle in which CE=1 and pc=0.
REQ-017 With CE held high, the first OS_TICK SHALL go high exactly div_r cycles after the LOAD/RESTART edge, then every div_r cycles; div_r=1 gives OS_TICK high every cycle.
REQ-018 Oversample counter oc (width clog2(OSR)) SHALL increment on each tick event (CE=1, pc=0), wrapping OSR-1 -> 0.
REQ-019 MID_TICK SHALL pulse coincident with the OS_TICK for which oc advanced from OSR/2-1 to OSR/2.
REQ-020 BIT_TICK SHALL pulse coincident with the OS_TICK for which oc wrapped OSR-1 -> 0.
REQ-021 After LOAD/RESTART with CE high: MID_TICK at (OSR/2)*div_r cycles, BIT_TICK at OSR*div_r cycles, then every OSR*div_r.
REQ-022 LOAD SHALL set div_r<=max(D,1), pc<=max(D,1)-1, oc<=0, and suppress any tick event in that cycle.
REQ-023 RESTART SHALL set pc<=div_r-1, oc<=0, and suppress any tick event in that cycle.
REQ-024 LOAD and RESTART in the same cycle: LOAD behaviour only.
REQ-025 LOAD and RESTART SHALL act regardless of CE.
REQ-026 CE=0: pc, oc hold; no ticks generated; pulses already registered complete normally (one cycle).
REQ-027 DIV SHALL equal div_r, updated the cycle after LOAD.
REQ-028 OS_TICK, MID_TICK, BIT_TICK SHALL never exceed one cycle high; MID_TICK and BIT_TICK never high together.

Reset
REQ-029 RST_N low SHALL asynchronously set div_r=DEF_DIV, pc=DEF_DIV-1, oc=0, OS_TICK=MID_TICK=BIT_TICK=0, DIV=DEF_DIV.
REQ-030 After RST_N deassertion, timing SHALL match REQ-017/021 measured from the first rising edge with RST_N high.
REQ-031 Reset asserted mid-count SHALL abandon the phase; no tick emitted during or on the edge after release.

Structure
REQ-032 OSR and DEF_DIV defaults SHALL reside in shared package uart_pkg, alongside UART frame constants.
REQ-033 Single module; no sub-module is natural.

Verification
REQ-034 Reset, CE=1, DIV_W=16, OSR=16, DEF_DIV=27 -> OS_TICK every 27 cycles, MID_TICK at cycle 216, BIT_TICK at 432, DIV=27.
REQ-035 LOAD D=5 mid-count -> DIV=5 next cycle, OS_TICK at +5, +10, ...; BIT_TICK at +80.
REQ-036 LOAD D=0 -> DIV=1, OS_TICK high every cycle, BIT_TICK every 16 cycles.
REQ-037 div=10, RESTART at oc=11 -> no tick that cycle, MID_TICK at +80, BIT_TICK at +160.
REQ-038 div=4, CE low 7 cycles in mid-count -> no ticks while low, tick schedule shifted by exactly 7 cycles.
REQ-039 LOAD D=8 and RESTART same cycle, then RST_N pulsed low mid-count -> DIV=8, then DIV=27, all outputs 0 immediately, first OS_TICK 27 cycles after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: oversample/divisor defaults for the baud generator
// and the serial frame layout used by the TX/RX blocks.
package uart_pkg;

  localparam int UART_OSR       = 16;
  localparam int UART_DEF_DIV   = 27;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  localparam int UART_FRAME_LEN = 1 + UART_DATA_BITS + UART_STOP_BITS;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: prescaler divides CLK down to the oversample rate,
// oversample counter derives mid-bit and bit-boundary ticks from it.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int               DIV_W   = 16,
  parameter int               OSR     = UART_OSR,
  parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(UART_DEF_DIV)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [DIV_W-1:0] D,
  input  logic             RESTART,
  output logic             OS_TICK,
  output logic             MID_TICK,
  output logic             BIT_TICK,
  output logic [DIV_W-1:0] DIV
);

  localparam int OC_W = $clog2(OSR);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pc_q, pc_d;
  logic [OC_W-1:0]  oc_q, oc_d;
  logic             os_q, os_d;
  logic             mid_q, mid_d;
  logic             bit_tick_q, bit_tick_d;
  logic [DIV_W-1:0] ld_div;
  logic             tick_ev;

  // LOAD/RESTART restart the phase, so a coincident zero-crossing never ticks.
  assign tick_ev = CE && (pc_q == '0) && !LOAD && !RESTART;
  assign ld_div  = (D == '0) ? DIV_W'(1) : D;

  always_comb begin
    div_d      = div_q;
    pc_d       = pc_q;
    oc_d       = oc_q;
    os_d       = tick_ev;
    mid_d      = tick_ev && (oc_q == OC_W'(OSR/2 - 1));
    bit_tick_d = tick_ev && (oc_q == OC_W'(OSR - 1));
    if (LOAD) begin
      div_d = ld_div;
      pc_d  = ld_div - DIV_W'(1);
      oc_d  = '0;
    end else if (RESTART) begin
      pc_d  = div_q - DIV_W'(1);
      oc_d  = '0;
    end else if (CE) begin
      if (pc_q == '0) begin
        pc_d = div_q - DIV_W'(1);
        oc_d = (oc_q == OC_W'(OSR - 1)) ? '0 : oc_q + OC_W'(1);
      end else begin
        pc_d = pc_q - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q      <= DEF_DIV;
      pc_q       <= DEF_DIV - DIV_W'(1);
      oc_q       <= '0;
      os_q       <= 1'b0;
      mid_q      <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pc_q       <= pc_d;
      oc_q       <= oc_d;
      os_q       <= os_d;
      mid_q      <= mid_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign OS_TICK  = os_q;
  assign MID_TICK = mid_q;
  assign BIT_TICK = bit_tick_q;
  assign DIV      = div_q;

endmodule
